// File: rtl/msi_snoop_cache_dm_param.sv
// Direct-mapped, write-back MSI snooping L1 cache with a multi-cycle miss FSM.
// CPU misses broadcast on the shared bus, take peer data when offered, else fill from memory.
module msi_snoop_cache_dm_param #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  localparam int ADDR_W = TAG_W + INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_req_valid,
  output logic [1:0]        bus_req_type,
  output logic [ADDR_W-1:0] bus_req_addr,
  input  logic              peer_data_valid,
  input  logic [DATA_W-1:0] peer_data,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_type,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  output logic              snoop_wb_valid,
  output logic [ADDR_W-1:0] snoop_wb_addr,
  output logic [DATA_W-1:0] snoop_wb_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] BUS_INVALIDATE = 2'b00;
  localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
  localparam logic [1:0] BUS_READ_MISS  = 2'b10;

  typedef enum logic [1:0] {
    LINE_I = 2'b00,
    LINE_M = 2'b01,
    LINE_S = 2'b10
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INV,
    ST_WB,
    ST_BUSREQ,
    ST_PEERWAIT,
    ST_FILL,
    ST_DONE
  } fsm_e;

  line_state_e       line_state [LINES];
  logic [TAG_W-1:0]  line_tag   [LINES];
  logic [DATA_W-1:0] line_data  [LINES];

  fsm_e              state, state_next;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] victim_addr;
  logic [DATA_W-1:0] victim_data;

  logic [INDEX_W-1:0] cpu_index, snp_index, req_index;
  logic [TAG_W-1:0]   cpu_tag, snp_tag, req_tag;
  logic               cpu_hit, victim_dirty, accept;
  logic               snp_match, snoop_kill, inv_abort;
  logic               install_now;
  logic [DATA_W-1:0]  fill_data;

  assign cpu_index = cpu_addr[INDEX_W-1:0];
  assign cpu_tag   = cpu_addr[ADDR_W-1:INDEX_W];
  assign snp_index = snoop_addr[INDEX_W-1:0];
  assign snp_tag   = snoop_addr[ADDR_W-1:INDEX_W];
  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];

  assign cpu_hit      = (line_state[cpu_index] != LINE_I) && (line_tag[cpu_index] == cpu_tag);
  assign victim_dirty = (line_state[cpu_index] == LINE_M);

  // A snoop to the index the CPU is asking for takes the line this cycle; the CPU retries next cycle.
  assign accept = (state == ST_IDLE) && (cpu_read ^ cpu_write)
               && !(snoop_valid && (snp_index == cpu_index));

  assign snp_match  = snoop_valid && (line_state[snp_index] != LINE_I)
                   && (line_tag[snp_index] == snp_tag);
  assign snoop_kill = snp_match && ((snoop_type == BUS_WRITE_MISS) || (snoop_type == BUS_INVALIDATE));
  assign inv_abort  = (state == ST_INV) && snoop_kill && (snp_index == req_index);

  assign install_now = ((state == ST_PEERWAIT) && peer_data_valid) || ((state == ST_FILL) && mem_ack);
  assign fill_data   = (state == ST_PEERWAIT) ? peer_data : mem_rdata;

  always_comb begin
    snoop_hit      = 1'b0;
    snoop_data     = '0;
    snoop_wb_valid = 1'b0;
    snoop_wb_addr  = '0;
    snoop_wb_data  = '0;
    if (snp_match && (line_state[snp_index] == LINE_M)
        && ((snoop_type == BUS_READ_MISS) || (snoop_type == BUS_WRITE_MISS))) begin
      snoop_hit      = 1'b1;
      snoop_data     = line_data[snp_index];
      snoop_wb_valid = 1'b1;
      snoop_wb_addr  = snoop_addr;
      snoop_wb_data  = line_data[snp_index];
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    state_next    = state;
    cpu_ready     = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_type  = BUS_INVALIDATE;
    bus_req_addr  = '0;
    mem_rd_req    = 1'b0;
    mem_wr_req    = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cpu_hit) begin
            if (cpu_read || victim_dirty) state_next = ST_DONE;
            else                          state_next = ST_INV;
          end else if (victim_dirty) begin
            state_next = ST_WB;
          end else begin
            state_next = ST_BUSREQ;
          end
        end
      end
      ST_INV: begin
        bus_req_valid = 1'b1;
        bus_req_type  = BUS_INVALIDATE;
        bus_req_addr  = req_addr;
        state_next    = inv_abort ? ST_BUSREQ : ST_DONE;
      end
      ST_WB: begin
        mem_wr_req = 1'b1;
        mem_addr   = victim_addr;
        mem_wdata  = victim_data;
        if (mem_ack) state_next = ST_BUSREQ;
      end
      ST_BUSREQ: begin
        bus_req_valid = 1'b1;
        bus_req_type  = req_write ? BUS_WRITE_MISS : BUS_READ_MISS;
        bus_req_addr  = req_addr;
        state_next    = ST_PEERWAIT;
      end
      ST_PEERWAIT: begin
        state_next = peer_data_valid ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = req_addr;
        if (mem_ack) state_next = ST_DONE;
      end
      ST_DONE: begin
        cpu_ready  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_addr    <= '0;
      req_write   <= 1'b0;
      req_wdata   <= '0;
      victim_addr <= '0;
      victim_data <= '0;
      cpu_rdata   <= '0;
      // NOTE: the line array is reset because coherence requires every line to start Invalid.
      for (int i = 0; i < LINES; i++) begin
        line_state[i] <= LINE_I;
        line_tag[i]   <= '0;
        line_data[i]  <= '0;
      end
    end else begin
      state <= state_next;

      if (snp_match && (line_state[snp_index] == LINE_M) && (snoop_type == BUS_READ_MISS))
        line_state[snp_index] <= LINE_S;
      else if (snoop_kill)
        line_state[snp_index] <= LINE_I;

      // FSM line updates come after the snoop update so the miss path's Invalid wins on a shared edge.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_addr  <= cpu_addr;
            req_write <= cpu_write;
            req_wdata <= cpu_wdata;
            if (cpu_hit) begin
              if (cpu_read)          cpu_rdata <= line_data[cpu_index];
              else if (victim_dirty) line_data[cpu_index] <= cpu_wdata;
            end else begin
              victim_addr <= {line_tag[cpu_index], cpu_index};
              victim_data <= line_data[cpu_index];
              if (!victim_dirty) line_state[cpu_index] <= LINE_I;
            end
          end
        end
        ST_INV: begin
          if (!inv_abort) begin
            line_state[req_index] <= LINE_M;
            line_data[req_index]  <= req_wdata;
          end
        end
        ST_WB: begin
          if (mem_ack) line_state[req_index] <= LINE_I;
        end
        ST_PEERWAIT, ST_FILL: begin
          if (install_now) begin
            line_tag[req_index] <= req_tag;
            if (req_write) begin
              line_state[req_index] <= LINE_M;
              line_data[req_index]  <= req_wdata;
            end else begin
              line_state[req_index] <= LINE_S;
              line_data[req_index]  <= fill_data;
              cpu_rdata             <= fill_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
